// File: rtl/rf_wb_pkg.sv
// Shared widths, RV32I load funct3 encodings and the load-extension helper
// used by the register-file writeback block.
package rf_wb_pkg;

  localparam int unsigned XLEN_W = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic f3_illegal(input logic [2:0] funct3);
    return !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  endfunction

  // Byte lane is addr_lo; half lane uses addr_lo[1] only. Illegal codes fall back to LW.
  function automatic logic [XLEN_W-1:0] load_extend(input logic [XLEN_W-1:0] data,
                                                    input logic [2:0]        funct3,
                                                    input logic [1:0]        addr_lo);
    logic [7:0]  w_b;
    logic [15:0] w_h;
    logic [XLEN_W-1:0] w_res;
    w_b = data[{addr_lo, 3'b000} +: 8];
    w_h = addr_lo[1] ? data[31:16] : data[15:0];
    case (funct3)
      F3_LB:   w_res = {{24{w_b[7]}}, w_b};
      F3_LH:   w_res = {{16{w_h[15]}}, w_h};
      F3_LBU:  w_res = {24'h0, w_b};
      F3_LHU:  w_res = {16'h0, w_h};
      default: w_res = data;
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small power-of-two FIFO holding queued ALU results {rd, data}.
// Synchronous active-low reset empties it; storage itself is not cleared.
module rf_wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 37
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_din,
  input  logic                       i_pop,
  output logic [W-1:0]               o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst_n && w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// Register-file write-port arbiter: loads win, ALU results queue in a FIFO.
// Optional macro RF_WB_BYPASS_EN adds rs1/rs2 forwarding from the write port.
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = XLEN_W,
  parameter int unsigned AW    = REG_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [AW-1:0]          alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   ld_valid,
  input  logic [AW-1:0]          ld_rd,
  input  logic [XLEN-1:0]        ld_data,
  input  logic [2:0]             ld_funct3,
  input  logic [1:0]             ld_addr_lo,
`ifdef RF_WB_BYPASS_EN
  input  logic [AW-1:0]          rs1,
  input  logic [AW-1:0]          rs2,
  input  logic [XLEN-1:0]        rf_rd1,
  input  logic [XLEN-1:0]        rf_rd2,
  output logic [XLEN-1:0]        fwd_rd1,
  output logic [XLEN-1:0]        fwd_rd2,
`endif
  output logic                   rf_we,
  output logic [AW-1:0]          rf_rd,
  output logic [XLEN-1:0]        rf_wd,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   ld_err
);

  localparam int unsigned EW = AW + XLEN;

  logic            w_full;
  logic            w_empty;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic [EW-1:0]   w_head;
  logic [XLEN-1:0] w_ld_ext;

  logic            r_we;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_wd;
  logic            r_ld_err;

  assign alu_ready = rst_n & ~w_full;
  assign w_accept  = alu_valid & alu_ready;
  // Queue only when the ALU result cannot go straight to the write port.
  assign w_push    = w_accept & (ld_valid | ~w_empty);
  assign w_pop     = ~ld_valid & ~w_empty;
  assign w_ld_ext  = load_extend(ld_data, ld_funct3, ld_addr_lo);

  rf_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   ({alu_rd, alu_data}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (pending)
  );

  // x0 destinations still update rd/wd but never raise the write enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_rd     <= '0;
      r_wd     <= '0;
      r_ld_err <= 1'b0;
    end else begin
      r_ld_err <= ld_valid & f3_illegal(ld_funct3);
      if (ld_valid) begin
        r_we <= (ld_rd != '0);
        r_rd <= ld_rd;
        r_wd <= w_ld_ext;
      end else if (!w_empty) begin
        r_we <= (w_head[XLEN +: AW] != '0);
        r_rd <= w_head[XLEN +: AW];
        r_wd <= w_head[XLEN-1:0];
      end else if (w_accept) begin
        r_we <= (alu_rd != '0);
        r_rd <= alu_rd;
        r_wd <= alu_data;
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign rf_we  = r_we;
  assign rf_rd  = r_rd;
  assign rf_wd  = r_wd;
  assign ld_err = r_ld_err;

`ifdef RF_WB_BYPASS_EN
  assign fwd_rd1 = (r_we && (r_rd == rs1) && (rs1 != '0)) ? r_wd : rf_rd1;
  assign fwd_rd2 = (r_we && (r_rd == rs2) && (rs2 != '0)) ? r_wd : rf_rd2;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Randomized self-checking bench for rf_writeback against a queue-based model.
// Define RF_WB_BYPASS_EN to also exercise the forwarding outputs.
module tb_rf_writeback;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [1:0]  pending;
  logic        ld_err;
`ifdef RF_WB_BYPASS_EN
  logic [4:0]  rs1, rs2;
  logic [31:0] rf_rd1, rf_rd2, fwd_rd1, fwd_rd2;
`endif

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  logic [36:0] q[$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        m_err;

  always #5 clk = ~clk;

  rf_writeback #(.DEPTH(DEPTH), .XLEN(32), .AW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
`ifdef RF_WB_BYPASS_EN
    .rs1        (rs1),
    .rs2        (rs2),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .fwd_rd1    (fwd_rd1),
    .fwd_rd2    (fwd_rd2),
`endif
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wd      (rf_wd),
    .pending    (pending),
    .ld_err     (ld_err)
  );

  function automatic logic [31:0] ref_ext(input logic [31:0] d, input logic [2:0] f3,
                                          input logic [1:0] a);
    logic [31:0] b, h;
    b = (d >> (8 * int'(a))) & 32'hFF;
    h = (d >> (16 * (int'(a) / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  function automatic logic exp_ready();
    return rst_n && (q.size() < DEPTH);
  endfunction

  // Advance one clock and update the model; no checking here.
  task automatic tick();
    logic acc;
    logic [36:0] e;
    acc = alu_valid && exp_ready();
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_we = 1'b0; m_rd = '0; m_wd = '0; m_err = 1'b0;
    end else begin
      m_err = ld_valid && (ld_funct3 inside {3'd3, 3'd6, 3'd7});
      if (ld_valid) begin
        m_rd = ld_rd; m_wd = ref_ext(ld_data, ld_funct3, ld_addr_lo); m_we = (ld_rd != 0);
        if (acc) q.push_back({alu_rd, alu_data});
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_rd = e[36:32]; m_wd = e[31:0]; m_we = (m_rd != 0);
        if (acc) q.push_back({alu_rd, alu_data});
      end else if (acc) begin
        m_rd = alu_rd; m_wd = alu_data; m_we = (alu_rd != 0);
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0; ld_funct3 = 3'd2; ld_addr_lo = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h77;
    #1;
    vectors++;
    if (alu_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready got=%b want=0", alu_ready);
    end
    tick(); tick();
    vectors++;
    if ({rf_we, rf_rd, rf_wd, ld_err, pending} !== {1'b0, 5'd0, 32'd0, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_state got we=%b rd=%0d wd=%h err=%b pend=%0d want all zero",
               rf_we, rf_rd, rf_wd, ld_err, pending);
    end
    idle_inputs(); rst_n = 1; #1;
  endtask

  task automatic test_single_alu();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick();
    alu_valid = 0;
    vectors++;
    if ({rf_we, rf_rd, rf_wd, pending} !== {1'b1, 5'd5, 32'h1234, 2'd0}) begin
      miscompares++;
      $display("FAIL single_alu got we=%b rd=%0d wd=%h pend=%0d want we=1 rd=5 wd=00001234 pend=0",
               rf_we, rf_rd, rf_wd, pending);
    end
    tick();
    vectors++;
    if (rf_we !== 1'b0) begin
      miscompares++; $display("FAIL single_alu_drop got we=%b want=0", rf_we);
    end
  endtask

  task automatic test_load_priority();
    int k = 1;
    logic [4:0] got[$];
    logic [4:0] want[8] = '{5'd10, 5'd10, 5'd10, 5'd10, 5'd1, 5'd2, 5'd3, 5'd4};
    logic want_rdy[7] = '{1, 1, 0, 0, 0, 1, 1};
    logic acc;
    for (int c = 0; c < 9; c++) begin
      ld_valid = (c < 4); ld_rd = 5'd10; ld_data = $urandom; ld_funct3 = 3'd2;
      alu_valid = (k <= 4); alu_rd = 5'(k); alu_data = 32'h100 + 32'(k);
      #1;
      if (c < 7) begin
        vectors++;
        if (alu_ready !== want_rdy[c]) begin
          miscompares++;
          $display("FAIL prio_ready cyc=%0d got=%b want=%b", c, alu_ready, want_rdy[c]);
        end
      end
      acc = alu_valid && alu_ready;
      tick();
      if (acc) k++;
      if (rf_we) got.push_back(rf_rd);
      vectors++;
      if ({rf_we, rf_rd, rf_wd, pending} !== {m_we, m_rd, m_wd, 2'(q.size())}) begin
        miscompares++;
        $display("FAIL prio_model cyc=%0d got we=%b rd=%0d wd=%h pend=%0d want we=%b rd=%0d wd=%h pend=%0d",
                 c, rf_we, rf_rd, rf_wd, pending, m_we, m_rd, m_wd, q.size());
      end
    end
    idle_inputs();
    vectors++;
    if (got.size() != 8) begin
      miscompares++; $display("FAIL prio_count got=%0d want=8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (got[i] !== want[i]) begin
          miscompares++; $display("FAIL prio_order idx=%0d got=%0d want=%0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3[7] = '{3'd0, 3'd0, 3'd5, 3'd1, 3'd3, 3'd4, 3'd2};
    logic [1:0]  al[7] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1};
    logic [31:0] wv[7] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF,
                           32'h80FF_7F01, 32'h0000_0080, 32'h80FF_7F01};
    logic        we[7] = '{0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h80FF_7F01; ld_funct3 = f3[i]; ld_addr_lo = al[i];
      tick();
      vectors++;
      if ({rf_we, rf_rd, rf_wd, ld_err} !== {1'b1, 5'd9, wv[i], we[i]}) begin
        miscompares++;
        $display("FAIL ld_ext f3=%0d lo=%0d got we=%b rd=%0d wd=%h err=%b want we=1 rd=9 wd=%h err=%b",
                 f3[i], al[i], rf_we, rf_rd, rf_wd, ld_err, wv[i], we[i]);
      end
    end
    idle_inputs();
    tick();
    vectors++;
    if ({rf_we, ld_err} !== 2'b00) begin
      miscompares++; $display("FAIL ld_err_clear got we=%b err=%b want 0 0", rf_we, ld_err);
    end
  endtask

  task automatic test_x0();
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    #1;
    vectors++;
    if (alu_ready !== 1'b1) begin
      miscompares++; $display("FAIL x0_ready got=%b want=1", alu_ready);
    end
    tick();
    vectors++;
    if ({rf_we, rf_rd, rf_wd} !== {1'b0, 5'd0, 32'hDEAD}) begin
      miscompares++;
      $display("FAIL x0_write got we=%b rd=%0d wd=%h want we=0 rd=0 wd=0000dead", rf_we, rf_rd, rf_wd);
    end
    alu_rd = 5'd6; alu_data = 32'h55;
    tick();
    alu_valid = 0;
    vectors++;
    if ({rf_we, rf_rd, rf_wd} !== {1'b1, 5'd6, 32'h55}) begin
      miscompares++;
      $display("FAIL x0_next got we=%b rd=%0d wd=%h want we=1 rd=6 wd=00000055", rf_we, rf_rd, rf_wd);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    ld_valid = 1; ld_rd = 5'd12; ld_data = 32'h1; ld_funct3 = 3'd2;
    alu_valid = 1; alu_rd = 5'd20; alu_data = 32'hA;
    tick();
    alu_rd = 5'd21; alu_data = 32'hB;
    tick();
    idle_inputs();
    vectors++;
    if (pending !== 2'd2) begin
      miscompares++; $display("FAIL rstmid_fill got pend=%0d want=2", pending);
    end
    rst_n = 0;
    tick();
    rst_n = 1; #1;
    vectors++;
    if ({rf_we, pending, alu_ready} !== {1'b0, 2'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL rstmid_after got we=%b pend=%0d rdy=%b want we=0 pend=0 rdy=1", rf_we, pending, alu_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (rf_we !== 1'b0) begin
        miscompares++; $display("FAIL rstmid_stale cyc=%0d got we=%b rd=%0d want we=0", i, rf_we, rf_rd);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst_n      = ($urandom_range(99) != 0);
      ld_valid   = ($urandom_range(2) == 0);
      ld_rd      = 5'($urandom_range(31));
      ld_data    = $urandom;
      ld_funct3  = 3'($urandom_range(7));
      ld_addr_lo = 2'($urandom_range(3));
      alu_valid  = ($urandom_range(1) == 0);
      alu_rd     = 5'($urandom_range(31));
      alu_data   = $urandom;
      #1;
      vectors++;
      if (alu_ready !== exp_ready()) begin
        miscompares++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, alu_ready, exp_ready());
      end
      tick();
      vectors++;
      if ({rf_we, rf_rd, rf_wd, ld_err, pending} !== {m_we, m_rd, m_wd, m_err, 2'(q.size())}) begin
        miscompares++;
        $display("FAIL rand_out cyc=%0d got we=%b rd=%0d wd=%h err=%b pend=%0d want we=%b rd=%0d wd=%h err=%b pend=%0d",
                 c, rf_we, rf_rd, rf_wd, ld_err, pending, m_we, m_rd, m_wd, m_err, q.size());
      end
    end
    rst_n = 1;
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();
  endtask

`ifdef RF_WB_BYPASS_EN
  task automatic test_bypass();
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'hAA;
    tick();
    alu_valid = 0;
    rs1 = 5'd7; rf_rd1 = 32'h11; rs2 = 5'd3; rf_rd2 = 32'h22;
    #1;
    vectors++;
    if ({fwd_rd1, fwd_rd2} !== {32'hAA, 32'h22}) begin
      miscompares++;
      $display("FAIL bypass_hit got fwd1=%h fwd2=%h want 000000aa 00000022", fwd_rd1, fwd_rd2);
    end
    rs1 = 5'd0; rs2 = 5'd7;
    #1;
    vectors++;
    if ({fwd_rd1, fwd_rd2} !== {32'h11, 32'hAA}) begin
      miscompares++;
      $display("FAIL bypass_x0 got fwd1=%h fwd2=%h want 00000011 000000aa", fwd_rd1, fwd_rd2);
    end
    tick();
    vectors++;
    if (fwd_rd2 !== 32'h22) begin
      miscompares++; $display("FAIL bypass_nowe got fwd2=%h want 00000022", fwd_rd2);
    end
  endtask
`endif

  initial begin
    q.delete();
    m_we = 0; m_rd = '0; m_wd = '0; m_err = 0;
`ifdef RF_WB_BYPASS_EN
    rs1 = '0; rs2 = '0; rf_rd1 = '0; rf_rd2 = '0;
`endif
    rst_n = 0;
    idle_inputs();
    #2;
    test_reset();
    test_single_alu();
    test_load_priority();
    test_load_extend();
    test_x0();
    test_reset_mid();
    test_random();
`ifdef RF_WB_BYPASS_EN
    test_bypass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
